// File: rtl/modport_stream_rx.sv
// rtl/modport_stream_rx.sv - valid/ready byte-stream receiver with show-ahead FIFO, XOR checksum and saturating beat count
module modport_stream_rx #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_valid,
    input  logic [WIDTH-1:0]         rx_data,
    output logic                     rx_ready,
    input  logic                     flush,
    input  logic                     deq,
    output logic                     deq_valid,
    output logic [WIDTH-1:0]         deq_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic [WIDTH-1:0]         sum,
    output logic [CNT_W-1:0]         rx_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             accept;
    logic             pop;

    // Ready is purely from registered state; a full FIFO never accepts even if the consumer pops.
    assign rx_ready  = !rst && !flush && (level != FULL);
    assign accept    = rx_valid && rx_ready;
    assign deq_valid = (level != '0);
    assign pop       = deq && deq_valid && !flush;
    assign deq_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            sum      <= '0;
            rx_count <= '0;
        end else begin
            if (accept) begin
                sum <= sum ^ rx_data;
                if (rx_count != '1) begin
                    rx_count <= rx_count + 1'b1;
                end
            end
            // Flush drops buffered beats but keeps the running checksum and count.
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (accept) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({accept, pop})
                    2'b10:   level <= level + 1'b1;
                    2'b01:   level <= level - 1'b1;
                    default: level <= level;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_modport_stream_rx.sv
// tb/tb_modport_stream_rx.sv - directed self-checking bench for modport_stream_rx
module tb_modport_stream_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        flush = 1'b0;
    logic        deq = 1'b0;

    logic        rx_ready, deq_valid;
    logic [7:0]  deq_data, sum;
    logic [2:0]  level;
    logic [15:0] rx_count;

    logic        s_rx_ready, s_deq_valid;
    logic [7:0]  s_deq_data, s_sum;
    logic [2:0]  s_level;
    logic [3:0]  s_rx_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic       p_hold = 1'b0;
    logic [7:0] p_data = 8'h00;

    modport_stream_rx #(.WIDTH(8), .DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .flush(flush), .deq(deq), .deq_valid(deq_valid), .deq_data(deq_data),
        .level(level), .sum(sum), .rx_count(rx_count)
    );

    modport_stream_rx #(.WIDTH(8), .DEPTH(4), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(s_rx_ready),
        .flush(flush), .deq(deq), .deq_valid(s_deq_valid), .deq_data(s_deq_data),
        .level(s_level), .sum(s_sum), .rx_count(s_rx_count)
    );

    always #5 clk = ~clk;

    // Transmitter must hold a stalled beat stable until it is accepted.
    always @(negedge clk) begin
        if (p_hold && !(rx_valid && rx_data == p_data)) begin
            n_checks++;
            $display("FAIL tx_hold: valid=%0b data=%h expected held data %h", rx_valid, rx_data, p_data);
        end
        p_hold <= rx_valid && !rx_ready && !rst && !flush;
        p_data <= rx_data;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; rx_valid = 1'b0; deq = 1'b0; flush = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; rx_valid = 1'b1; rx_data = 8'hEE;
        #1;
        n_checks++;
        if (rx_ready !== 1'b0) $display("FAIL reset_ready_low: got %b expected 0", rx_ready); else n_pass++;
        tick();
        rst = 1'b0; rx_valid = 1'b0;
        #1;
        n_checks++;
        if (level !== 3'd0) $display("FAIL reset_level: got %0d expected 0", level); else n_pass++;
        n_checks++;
        if (deq_valid !== 1'b0) $display("FAIL reset_deq_valid: got %b expected 0", deq_valid); else n_pass++;
        n_checks++;
        if (rx_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", rx_ready); else n_pass++;
        n_checks++;
        if (sum !== 8'h00) $display("FAIL reset_sum: got %h expected 00", sum); else n_pass++;
        n_checks++;
        if (rx_count !== 16'd0) $display("FAIL reset_count: got %0d expected 0", rx_count); else n_pass++;
    endtask

    task automatic test_fill;
        do_reset();
        rx_valid = 1'b1;
        rx_data = 8'h11; tick();
        rx_data = 8'h22; tick();
        rx_data = 8'h33; tick();
        rx_valid = 1'b0;
        #1;
        n_checks++;
        if (level !== 3'd3) $display("FAIL fill_level: got %0d expected 3", level); else n_pass++;
        n_checks++;
        if (deq_data !== 8'h11) $display("FAIL fill_head: got %h expected 11", deq_data); else n_pass++;
        n_checks++;
        if (sum !== 8'h00) $display("FAIL fill_sum: got %h expected 00", sum); else n_pass++;
        n_checks++;
        if (rx_count !== 16'd3) $display("FAIL fill_count: got %0d expected 3", rx_count); else n_pass++;
        n_checks++;
        if (rx_ready !== 1'b1) $display("FAIL fill_ready: got %b expected 1", rx_ready); else n_pass++;
    endtask

    task automatic test_backpressure;
        do_reset();
        rx_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            rx_data = 8'(i);
            tick();
        end
        rx_data = 8'h05;
        #1;
        n_checks++;
        if (rx_ready !== 1'b0) $display("FAIL bp_full_ready: got %b expected 0", rx_ready); else n_pass++;
        tick();
        n_checks++;
        if (level !== 3'd4) $display("FAIL bp_full_level: got %0d expected 4", level); else n_pass++;
        n_checks++;
        if (rx_count !== 16'd4) $display("FAIL bp_stall_count: got %0d expected 4", rx_count); else n_pass++;
        n_checks++;
        if (deq_data !== 8'h01) $display("FAIL bp_order_1: got %h expected 01", deq_data); else n_pass++;
        deq = 1'b1;
        tick();
        deq = 1'b0;
        #1;
        n_checks++;
        if (rx_ready !== 1'b1) $display("FAIL bp_ready_after_pop: got %b expected 1", rx_ready); else n_pass++;
        tick();
        rx_valid = 1'b0;
        #1;
        n_checks++;
        if (level !== 3'd4) $display("FAIL bp_refill_level: got %0d expected 4", level); else n_pass++;
        n_checks++;
        if (rx_count !== 16'd5) $display("FAIL bp_refill_count: got %0d expected 5", rx_count); else n_pass++;
        deq = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            n_checks++;
            if (deq_data !== 8'(i)) $display("FAIL bp_order_%0d: got %h expected %h", i, deq_data, 8'(i)); else n_pass++;
            tick();
        end
        deq = 1'b0;
        #1;
        n_checks++;
        if (deq_valid !== 1'b0) $display("FAIL bp_drained: got %b expected 0", deq_valid); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_sum;
        exp_sum = 8'h00;
        do_reset();
        rx_valid = 1'b1; deq = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rx_data = 8'(i);
            exp_sum = exp_sum ^ 8'(i);
            #1;
            n_checks++;
            if (rx_ready !== 1'b1) $display("FAIL b2b_ready_%0d: got %b expected 1", i, rx_ready); else n_pass++;
            n_checks++;
            if (level !== ((i == 0) ? 3'd0 : 3'd1)) $display("FAIL b2b_level_%0d: got %0d expected %0d", i, level, (i == 0) ? 0 : 1); else n_pass++;
            if (i > 0) begin
                n_checks++;
                if (deq_data !== 8'(i - 1)) $display("FAIL b2b_order_%0d: got %h expected %h", i, deq_data, 8'(i - 1)); else n_pass++;
            end
            tick();
        end
        rx_valid = 1'b0;
        #1;
        n_checks++;
        if (deq_data !== 8'd19) $display("FAIL b2b_last: got %h expected 13", deq_data); else n_pass++;
        tick();
        deq = 1'b0;
        #1;
        n_checks++;
        if (level !== 3'd0) $display("FAIL b2b_empty: got %0d expected 0", level); else n_pass++;
        n_checks++;
        if (sum !== exp_sum) $display("FAIL b2b_sum: got %h expected %h", sum, exp_sum); else n_pass++;
        n_checks++;
        if (rx_count !== 16'd20) $display("FAIL b2b_count: got %0d expected 20", rx_count); else n_pass++;
    endtask

    task automatic test_flush;
        do_reset();
        rx_valid = 1'b1;
        rx_data = 8'hA1; tick();
        rx_data = 8'hB2; tick();
        rx_data = 8'hC3; tick();
        rx_data = 8'hD4; deq = 1'b1; flush = 1'b1;
        #1;
        n_checks++;
        if (rx_ready !== 1'b0) $display("FAIL flush_ready: got %b expected 0", rx_ready); else n_pass++;
        tick();
        flush = 1'b0; rx_valid = 1'b0; deq = 1'b0;
        #1;
        n_checks++;
        if (level !== 3'd0) $display("FAIL flush_level: got %0d expected 0", level); else n_pass++;
        n_checks++;
        if (deq_valid !== 1'b0) $display("FAIL flush_deq_valid: got %b expected 0", deq_valid); else n_pass++;
        n_checks++;
        if (sum !== 8'hD0) $display("FAIL flush_sum: got %h expected d0", sum); else n_pass++;
        n_checks++;
        if (rx_count !== 16'd3) $display("FAIL flush_count: got %0d expected 3", rx_count); else n_pass++;
        n_checks++;
        if (rx_ready !== 1'b1) $display("FAIL flush_ready_after: got %b expected 1", rx_ready); else n_pass++;
    endtask

    task automatic test_reset_mid;
        do_reset();
        rx_valid = 1'b1;
        rx_data = 8'h5A; tick();
        rx_data = 8'h3C; tick();
        rx_data = 8'h77; rst = 1'b1;
        #1;
        n_checks++;
        if (rx_ready !== 1'b0) $display("FAIL rstmid_ready: got %b expected 0", rx_ready); else n_pass++;
        tick();
        rst = 1'b0; rx_valid = 1'b0;
        #1;
        n_checks++;
        if (level !== 3'd0) $display("FAIL rstmid_level: got %0d expected 0", level); else n_pass++;
        n_checks++;
        if (sum !== 8'h00) $display("FAIL rstmid_sum: got %h expected 00", sum); else n_pass++;
        n_checks++;
        if (rx_count !== 16'd0) $display("FAIL rstmid_count: got %0d expected 0", rx_count); else n_pass++;
        n_checks++;
        if (rx_ready !== 1'b1) $display("FAIL rstmid_ready_after: got %b expected 1", rx_ready); else n_pass++;
    endtask

    task automatic test_saturate;
        do_reset();
        rx_valid = 1'b1; deq = 1'b1;
        for (int k = 0; k < 20; k++) begin
            rx_data = 8'(k + 1);
            #1;
            if (k > 0) begin
                n_checks++;
                if (s_deq_data !== 8'(k)) $display("FAIL sat_flow_%0d: got %h expected %h", k, s_deq_data, 8'(k)); else n_pass++;
            end
            tick();
            n_checks++;
            if (s_rx_count !== ((k + 1 > 15) ? 4'hF : 4'(k + 1)))
                $display("FAIL sat_count_%0d: got %h expected %h", k, s_rx_count, (k + 1 > 15) ? 4'hF : 4'(k + 1));
            else n_pass++;
        end
        rx_valid = 1'b0; deq = 1'b0;
        #1;
        n_checks++;
        if (rx_count !== 16'd20) $display("FAIL sat_wide_count: got %0d expected 20", rx_count); else n_pass++;
        n_checks++;
        if (s_deq_data !== 8'd20) $display("FAIL sat_last: got %h expected 14", s_deq_data); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/modport_stream_rx.md
Name: modport_stream_rx

Overview:
- Receiving end of a valid/ready byte stream carried over an interface modport whose members are bound by modport expressions.
- The block accepts beats from a transmitter, buffers them in a small show-ahead FIFO, and presents them to a local consumer.
- It also keeps a running XOR checksum and a saturating beat count so the enclosing test top can self-check.
- It sits opposite a transmitter module on the same interface instance; the top wires the modport-expression members to the rx_* ports.

Parameters:
- WIDTH, 8: data width of one beat.
- DEPTH, 4: FIFO entries. Must be a power of two and at least 2.
- CNT_W, 16: width of the beat counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- rx_valid  input  1  transmitter has a beat on rx_data.
- rx_data  input  WIDTH  beat payload.
- rx_ready  output  1  block can accept a beat this cycle.
- flush  input  1  discard all buffered beats.
- deq  input  1  consumer pops the head entry.
- deq_valid  output  1  head entry is valid.
- deq_data  output  WIDTH  head entry (show-ahead).
- level  output  $clog2(DEPTH)+1  number of buffered entries.
- sum  output  WIDTH  XOR of every accepted beat since reset.
- rx_count  output  CNT_W  accepted beats since reset; saturates.

Behaviour:
- Reset: one clock, synchronous, active-high (rst sampled on rising clk edge). The following registers clear to 0 on the edge where rst=1: wr_ptr, rd_ptr, level, sum, rx_count. Resulting outputs: level=0, deq_valid=0, rx_ready=1 once rst=0, sum=0, rx_count=0.
- Reset mid-operation drops all buffered data. FIFO memory contents are not cleared; deq_data is don't-care while deq_valid=0.
- rx_ready is combinational from registered state: rx_ready = !rst && !flush && (level != DEPTH). It does not depend on rx_valid or deq (no full-bypass).
- Accept = rx_valid && rx_ready. On accept: mem[wr_ptr] <= rx_data, wr_ptr increments modulo DEPTH, sum <= sum ^ rx_data, and rx_count increments unless it equals all-ones (saturate; it never wraps).
- Transmitter protocol: once rx_valid rises it holds rx_valid and rx_data stable until accepted. The block does not check this; the bench asserts it.
- Pop = deq && deq_valid. On pop: rd_ptr increments modulo DEPTH. deq while empty is ignored.
- deq_valid = (level != 0). deq_data = mem[rd_ptr], combinational read.
- A written beat appears on deq_data one cycle after acceptance (no write-to-read bypass).
- level next value: +1 on accept only, -1 on pop only, unchanged on both or neither.
- Simultaneous accept and pop at level=DEPTH is impossible (rx_ready=0).
- At level=0 an accept with deq=1 gives a push only; level becomes 1.
- Pointers wrap at DEPTH without losing order.
- flush=1 at an edge:
  - wr_ptr, rd_ptr and level clear to 0.
  - No accept occurs, because rx_ready is low during flush.
  - Any pop in the same cycle is void.
  - sum and rx_count are kept.
- rst has priority over flush; flush has priority over accept and pop.
- Throughput: one beat per cycle sustained when the consumer pops every cycle and level < DEPTH.

Test Plan:
1. Reset, then send 0x11, 0x22, 0x33 back-to-back with deq=0. Required: level=3, deq_data=0x11, sum=0x00, rx_count=3, rx_ready=1.
2. Send 5 beats 0x01..0x05 with deq=0 (DEPTH=4). Required: rx_ready=0 after 4 accepts, 0x05 held by the transmitter. Then pop once: 0x05 is accepted the next cycle, level=4, and the deq order is 01,02,03,04,05.
3. Hold rx_valid=1 and deq=1 continuously for 20 cycles with incrementing data. Required: one accept per cycle, level stays ≤1, output order equals input order across pointer wrap, sum equals the XOR of 0..19 = 0x00... The bench computes and compares the XOR value.
4. Load 3 beats, then assert flush with rx_valid=1 and deq=1 for one cycle. Required: rx_ready=0 that cycle, level=0 and deq_valid=0 next cycle, sum and rx_count unchanged.
5. Load 2 beats, then pulse rst with rx_valid=1. Required: no accept on the reset edge, and afterward level=0, sum=0, rx_count=0, rx_ready=1.
6. Force rx_count to all-ones via CNT_W=4 and send 20 beats. Required: rx_count stays at 0xF after the 15th accept, and data still flows.
